// File: rtl/circular_correlation_if.sv
// Ready/valid window bus for circular_correlation: key and operand vectors in, result window out.
interface circular_correlation_if #(
   parameter int unsigned QLEN        = 16,
   parameter int unsigned WINDOW_SIZE = 16
);
   localparam int unsigned VEC_W = QLEN * WINDOW_SIZE;

   logic [VEC_W-1:0] weights;
   logic             in_valid;
   logic             in_ready;
   logic [VEC_W-1:0] in_data;
   logic             out_valid;
   logic [VEC_W-1:0] out_data;

   modport master (
      output weights, in_valid, in_data,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  weights, in_valid, in_data,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/circular_correlation.sv
// Circular correlation y[k] = sum_j w[j]*x[(j+k) mod N], one element per cycle.
// Define CIRC_CORR_SATURATE_EN to clamp results to the QLEN range instead of wrapping.
module circular_correlation #(
   parameter int unsigned QLEN        = 16,
   parameter int unsigned FRAC_W      = 12,
   parameter int unsigned WINDOW_SIZE = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   circular_correlation_if.slave bus
);
   localparam int unsigned N     = WINDOW_SIZE;
   localparam int unsigned PTR_W = $clog2(N);
   localparam int unsigned SUM_W = 2 * QLEN + $clog2(N);

   typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH} state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [PTR_W-1:0]        ptr;
   logic signed [QLEN-1:0]  rot_r [N];
   logic signed [QLEN-1:0]  w_r   [N];
   logic signed [QLEN-1:0]  out_r [N];
   logic signed [QLEN-1:0]  stage_res;
   logic [PTR_W-1:0]        stage_idx;
   logic                    stage_vld;
   logic                    out_valid_r;
   logic                    accept_c;
   logic signed [SUM_W-1:0] sum_c;
   logic signed [SUM_W-1:0] shifted_c;
   logic signed [QLEN-1:0]  reduced_c;

   assign accept_c = bus.in_valid && (state == IDLE);

   // Dot product of the key against the current rotation, full precision then rescaled
   always_comb begin
      sum_c = '0;
      for (int j = 0; j < int'(N); j++) begin
         sum_c = sum_c + SUM_W'(w_r[j]) * SUM_W'(rot_r[j]);
      end
      shifted_c = sum_c >>> FRAC_W;
`ifdef CIRC_CORR_SATURATE_EN
      if (shifted_c > $signed({{(SUM_W-QLEN+1){1'b0}}, {(QLEN-1){1'b1}}})) begin
         reduced_c = {1'b0, {(QLEN-1){1'b1}}};
      end else if (shifted_c < $signed({{(SUM_W-QLEN+1){1'b1}}, {(QLEN-1){1'b0}}})) begin
         reduced_c = {1'b1, {(QLEN-1){1'b0}}};
      end else begin
         reduced_c = QLEN'(shifted_c);
      end
`else
      reduced_c = QLEN'(shifted_c);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = COMPUTE;
         COMPUTE: if (ptr == PTR_W'(N - 1)) state_nx = FLUSH;
         FLUSH:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, rotation, one-deep result stage and output window write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         stage_res   <= '0;
         stage_idx   <= '0;
         stage_vld   <= 1'b0;
         out_valid_r <= 1'b0;
         for (int j = 0; j < int'(N); j++) begin
            rot_r[j] <= '0;
            w_r[j]   <= '0;
            out_r[j] <= '0;
         end
      end else begin
         stage_vld   <= (state == COMPUTE);
         out_valid_r <= (state == FLUSH);
         if (accept_c) begin
            ptr <= '0;
            for (int j = 0; j < int'(N); j++) begin
               rot_r[j] <= bus.in_data[j*QLEN +: QLEN];
               w_r[j]   <= bus.weights[j*QLEN +: QLEN];
            end
         end else if (state == COMPUTE) begin
            stage_res <= reduced_c;
            stage_idx <= ptr;
            ptr       <= (ptr == PTR_W'(N - 1)) ? '0 : ptr + PTR_W'(1);
            for (int j = 0; j < int'(N); j++) begin
               rot_r[j] <= rot_r[(j + 1) % int'(N)];
            end
         end
         if (stage_vld) out_r[stage_idx] <= stage_res;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_r;

   for (genvar g = 0; g < int'(N); g++) begin : g_out
      assign bus.out_data[g*QLEN +: QLEN] = out_r[g];
   end
endmodule

// File: tb/tb_circular_correlation.sv
// Directed bench for circular_correlation at N=4, Q4.12 elements.
module tb_circular_correlation;
   localparam int unsigned QLEN = 16;
   localparam int unsigned N    = 4;
   localparam int unsigned VW   = QLEN * N;

   typedef struct {
      string         name;
      logic [VW-1:0] w;
      logic [VW-1:0] x;
      logic [VW-1:0] y;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   vec_t tbl [7];

   circular_correlation_if #(.QLEN(QLEN), .WINDOW_SIZE(N)) bus ();

   circular_correlation #(.QLEN(QLEN), .FRAC_W(12), .WINDOW_SIZE(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] pk(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int cyc;
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check({name, "_ready_timeout"}, VW'(bus.in_ready), VW'(1));
   endtask

   // One isolated frame: accept, busy window, single out_valid pulse, stable result
   task automatic run_frame(input string name, input logic [VW-1:0] w,
                            input logic [VW-1:0] x, input logic [VW-1:0] y);
      wait_ready(name);
      bus.weights  = w;
      bus.in_data  = x;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.weights  = {$urandom, $urandom};
      bus.in_data  = {$urandom, $urandom};
      for (int k = 1; k <= 4; k++) begin
         tick();
         check({name, "_busy_ready"}, VW'(bus.in_ready), VW'(0));
         check({name, "_busy_valid"}, VW'(bus.out_valid), VW'(0));
      end
      tick();
      check({name, "_valid"}, VW'(bus.out_valid), VW'(1));
      check({name, "_ready_at_valid"}, VW'(bus.in_ready), VW'(1));
      check({name, "_data"}, bus.out_data, y);
      tick();
      check({name, "_valid_drop"}, VW'(bus.out_valid), VW'(0));
      check({name, "_data_hold"}, bus.out_data, y);
   endtask

   initial begin
      logic [VW-1:0] xa, wa, ya, xb, wb, yb;
      int            seen;
      n_cmp  = 0;
      n_fail = 0;

      tbl[0] = '{"identity", pk(16'h1000, 0, 0, 0), pk(16'h1000, 16'h2000, 16'h3000, 16'h4000),
                 pk(16'h1000, 16'h2000, 16'h3000, 16'h4000)};
      tbl[1] = '{"rot1", pk(0, 16'h1000, 0, 0), pk(16'h1000, 16'h2000, 16'h3000, 16'h4000),
                 pk(16'h2000, 16'h3000, 16'h4000, 16'h1000)};
      tbl[2] = '{"neg_one", pk(16'hF000, 0, 0, 0), pk(16'h1000, 16'h0800, 16'h0000, 16'h7FFF),
                 pk(16'hF000, 16'hF800, 16'h0000, 16'h8001)};
      tbl[3] = '{"half_pair", pk(16'h0800, 16'h0800, 0, 0), pk(16'h1000, 16'h2000, 16'h3000, 16'h4000),
                 pk(16'h1800, 16'h2800, 16'h3800, 16'h2800)};
      tbl[4] = '{"floor", pk(16'h0001, 0, 0, 0), pk(16'hFFFF, 16'h0001, 16'h1000, 16'hF000),
                 pk(16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF)};
`ifdef CIRC_CORR_SATURATE_EN
      tbl[5] = '{"ovf_pos", {4{16'h4000}}, {4{16'h4000}}, {4{16'h7FFF}}};
      tbl[6] = '{"ovf_neg", {4{16'h4000}}, {4{16'hC000}}, {4{16'h8000}}};
`else
      tbl[5] = '{"ovf_pos", {4{16'h4000}}, {4{16'h4000}}, {4{16'h0000}}};
      tbl[6] = '{"ovf_neg", {4{16'h4000}}, {4{16'hC000}}, {4{16'h0000}}};
`endif

      // Reset, with in_valid asserted while held
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.weights  = tbl[0].w;
      bus.in_data  = tbl[0].x;
      tick();
      tick();
      check("rst_ready", VW'(bus.in_ready), VW'(1));
      check("rst_valid", VW'(bus.out_valid), VW'(0));
      check("rst_data", bus.out_data, '0);
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", VW'(bus.in_ready), VW'(1));

      for (int i = 0; i < 7; i++) run_frame(tbl[i].name, tbl[i].w, tbl[i].x, tbl[i].y);

      // Back-to-back frames with in_valid held high
      wa = tbl[0].w; xa = tbl[0].x; ya = tbl[0].y;
      wb = pk(0, 0, 16'h1000, 0);
      xb = pk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
      yb = pk(16'h0300, 16'h0400, 16'h0100, 16'h0200);
      wait_ready("b2b");
      bus.weights  = wa;
      bus.in_data  = xa;
      bus.in_valid = 1'b1;
      tick();
      bus.weights = wb;
      bus.in_data = xb;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("b2b_a_busy", VW'(bus.in_ready), VW'(0));
      end
      tick();
      check("b2b_a_valid", VW'(bus.out_valid), VW'(1));
      check("b2b_a_data", bus.out_data, ya);
      check("b2b_a_ready", VW'(bus.in_ready), VW'(1));
      tick();
      check("b2b_b_accepted", VW'(bus.in_ready), VW'(0));
      check("b2b_b_valid_low", VW'(bus.out_valid), VW'(0));
      bus.in_valid = 1'b0;
      bus.weights  = {$urandom, $urandom};
      bus.in_data  = {$urandom, $urandom};
      tick();
      check("b2b_a_data_stable", bus.out_data, ya);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("b2b_b_not_yet", VW'(bus.out_valid), VW'(0));
      tick();
      check("b2b_b_valid", VW'(bus.out_valid), VW'(1));
      check("b2b_b_data", bus.out_data, yb);
      tick();
      check("b2b_b_pulse_end", VW'(bus.out_valid), VW'(0));
      check("b2b_idle", VW'(bus.in_ready), VW'(1));

      // Reset during COMPUTE k=2 abandons the frame
      bus.weights  = wb;
      bus.in_data  = xb;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_data", bus.out_data, '0);
      check("midrst_ready", VW'(bus.in_ready), VW'(1));
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.out_valid === 1'b1) seen++;
      end
      check("midrst_no_pulse", VW'(seen), VW'(0));
      check("midrst_data_after", bus.out_data, '0);
      run_frame("after_rst", tbl[0].w, tbl[0].x, tbl[0].y);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
